muldiv_unit: RTL

- Iterative multiply/divide unit for the RV32M extension of the RV32IM core.
- Sits in the execute stage beside the combinational ALU and takes the same s1/s2 operands.
- Computes one M-extension operation per request through a start/busy/done handshake.
- The execute stage stalls on busy.

---
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction and result select before writeback.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] s1,
    input  logic [DATA_WIDTH-1:0] s2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] MD_OUT,
    output logic [1:0]            dbg_state
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    // Handshake: start is sampled only in S_IDLE; busy covers the start edge up to the
    // result edge; done is a one-cycle pulse with MD_OUT valid in that same cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            spec_q, spec_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    md_out_q, md_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Operand signedness and magnitudes at capture; -MIN_NEG wraps to 2^(W-1) as wanted.
    logic         s1_signed, s2_signed, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         div_zero, div_ovf;

    assign s1_signed = (funct3 != F_MULHU) && (funct3 != F_DIVU) && (funct3 != F_REMU);
    assign s2_signed = s1_signed && (funct3 != F_MULHSU);
    assign a_neg     = s1_signed & s1[W-1];
    assign b_neg     = s2_signed & s2[W-1];
    assign a_mag     = a_neg ? -s1 : s1;
    assign b_mag     = b_neg ? -s2 : s2;
    assign div_zero  = funct3[2] && (s2 == '0);
    assign div_ovf   = ((funct3 == F_DIV) || (funct3 == F_REM)) && (s1 == MIN_NEG) && (s2 == '1);

    // One iteration step; prod_q holds {hi, lo} for multiply and {rem, quo} for divide.
    logic [W:0] mul_sum;
    logic [W:0] div_shift, div_diff;
    logic       div_ge;

    assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {prod_q[2*W-1:W], prod_q[W-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_ge    = ~div_diff[W];

    logic [2*W-1:0] prod_sel;
    logic [W-1:0]   quo_fix, rem_fix;

    assign prod_sel = neg_q ? -prod_q : prod_q;
    assign quo_fix  = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];
    assign rem_fix  = rneg_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        spec_d   = spec_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        res_d    = res_q;
        md_out_d = md_out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = funct3;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    spec_d = 1'b0;
                    if (funct3[2]) begin
                        mcand_d = b_mag;
                        prod_d  = {{W{1'b0}}, a_mag};
                        neg_d   = (funct3 == F_DIV) && (a_neg ^ b_neg);
                        rneg_d  = (funct3 == F_REM) && a_neg;
                    end else begin
                        mcand_d = a_mag;
                        prod_d  = {{W{1'b0}}, b_mag};
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = 1'b0;
                    end
                    if (div_zero) begin
                        res_d   = funct3[1] ? s1 : '1;
                        spec_d  = 1'b1;
                        state_d = S_FIX;
                    end else if (div_ovf) begin
                        res_d   = funct3[1] ? '0 : MIN_NEG;
                        spec_d  = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (op_q[2]) begin
                    prod_d = div_ge ? {div_diff[W-1:0], prod_q[W-2:0], 1'b1}
                                    : {div_shift[W-1:0], prod_q[W-2:0], 1'b0};
                end else begin
                    prod_d = {mul_sum, prod_q[W-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (!spec_q) begin
                    case (op_q)
                        F_MUL:                     res_d = prod_sel[W-1:0];
                        F_MULH, F_MULHSU, F_MULHU: res_d = prod_sel[2*W-1:W];
                        F_DIV, F_DIVU:             res_d = quo_fix;
                        default:                   res_d = rem_fix;
                    endcase
                end
                state_d = S_WB;
            end

            S_WB: begin
                md_out_d = res_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            spec_q   <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            md_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            spec_q   <= spec_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            md_out_q <= md_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign MD_OUT    = md_out_q;
    assign dbg_state = state_q;

endmodule
